hit_tracker: RTL and testbench

- Per-frame hit/click tracker for the ray-traced renderer; successor to the single-probe centre-pixel hit detector.
- Watches the pixel write stream for NUM_PROBES configurable screen coordinates and keeps the closest hit object per probe.
- On each frame boundary it commits results to stable outputs and, if the player clicked while probe 0 hit, pushes a hit event into a small FIFO.
- Sits between the tracer's pixel writer and game logic (scoring/object removal).

---
 rtl/hit_tracker.sv | 222 ++++++++++++++++++++++
 tb/tb_hit_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hit_tracker.sv
// Per-frame probe-pixel hit tracker: keeps the closest hit per probe, commits on frame_clk rising edges
// and queues click-confirmed crosshair hits. Optional click debounce: HIT_TRACKER_DEBOUNCE_EN.
module hit_tracker #(
    parameter int              NUM_PROBES = 4,
    parameter int              IDX_W      = 2,
    parameter int              T_W        = 64,
    parameter logic [T_W-1:0]  T_MISS     = 64'hEFFFFFFFFFFFFFFF,
    parameter int              FIFO_DEPTH = 4,
    parameter int              SCORE_W    = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_clk,
    input  logic                        click,
    input  logic                        WritePixel,
    input  logic [9:0]                  WriteX,
    input  logic [9:0]                  WriteY,
    input  logic [T_W-1:0]              tbest,
    input  logic [IDX_W-1:0]            best_in,
    input  logic [NUM_PROBES*20-1:0]    probe_xy,
    output logic [NUM_PROBES-1:0]       hit_mask,
    output logic [NUM_PROBES*IDX_W-1:0] hit_index,
    output logic                        hit,
    output logic                        evt_valid,
    output logic [IDX_W-1:0]            evt_index,
    input  logic                        evt_ready,
    output logic                        evt_overflow,
    output logic [SCORE_W-1:0]          score
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    fc_q_r;
    logic                    frame_edge_s;
    logic                    commit_s;
    logic [NUM_PROBES-1:0]   upd_s;
    logic                    click_set_s;

    logic [T_W-1:0]          work_t_r   [NUM_PROBES];
    logic [IDX_W-1:0]        work_idx_r [NUM_PROBES];
    logic [NUM_PROBES-1:0]   work_hit_r;
    logic                    work_click_r;

    logic [IDX_W-1:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W:0]          count_r;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    wr_en_s;

    assign frame_edge_s = frame_clk & ~fc_q_r;

    // Frame strobe history for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_q_r <= 1'b0;
        end else begin
            fc_q_r <= frame_clk;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= COLLECT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state; an edge seen during COMMIT is ignored
    always_comb begin
        next_state_s = state_r;
        commit_s     = 1'b0;
        case (state_r)
            COLLECT: begin
                if (frame_edge_s) begin
                    next_state_s = COMMIT;
                    commit_s     = 1'b1;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            COMMIT:  next_state_s = COLLECT;
            default: next_state_s = COLLECT;
        endcase
    end

    // Per-probe closer-hit detection; writes in the edge cycle are dropped
    always_comb begin
        upd_s = '0;
        for (int p = 0; p < NUM_PROBES; p++) begin
            upd_s[p] = ~commit_s & WritePixel
                     & (WriteX == probe_xy[p*20+10 +: 10])
                     & (WriteY == probe_xy[p*20 +: 10])
                     & (tbest != T_MISS)
                     & (tbest < work_t_r[p]);
        end
    end

`ifdef HIT_TRACKER_DEBOUNCE_EN
    logic       sync1_r;
    logic       sync2_r;
    logic [7:0] db_cnt_r;

    // 16th consecutive synchronised-high cycle qualifies the click
    assign click_set_s = sync2_r & (db_cnt_r >= 8'd15);

    // Click synchroniser and consecutive-high counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            db_cnt_r <= 8'd0;
        end else begin
            sync1_r <= click;
            sync2_r <= sync1_r;
            if (commit_s || !sync2_r) begin
                db_cnt_r <= 8'd0;
            end else if (db_cnt_r != 8'hFF) begin
                db_cnt_r <= db_cnt_r + 8'd1;
            end
        end
    end
`else
    assign click_set_s = click;
`endif

    // Working (current-frame) registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            work_hit_r   <= '0;
            work_click_r <= 1'b0;
            for (int p = 0; p < NUM_PROBES; p++) begin
                work_t_r[p]   <= T_MISS;
                work_idx_r[p] <= '0;
            end
        end else if (commit_s) begin
            work_hit_r   <= '0;
            work_click_r <= click_set_s;
            for (int p = 0; p < NUM_PROBES; p++) begin
                work_t_r[p]   <= T_MISS;
                work_idx_r[p] <= '0;
            end
        end else begin
            work_click_r <= work_click_r | click_set_s;
            for (int p = 0; p < NUM_PROBES; p++) begin
                if (upd_s[p]) begin
                    work_hit_r[p] <= 1'b1;
                    work_t_r[p]   <= tbest;
                    work_idx_r[p] <= best_in;
                end
            end
        end
    end

    // Committed per-frame results
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit_mask  <= '0;
            hit_index <= '0;
            hit       <= 1'b0;
        end else if (commit_s) begin
            hit_mask <= work_hit_r;
            hit      <= work_hit_r[0] & work_click_r;
            for (int p = 0; p < NUM_PROBES; p++) begin
                hit_index[p*IDX_W +: IDX_W] <= work_idx_r[p];
            end
        end
    end

    assign push_s    = (state_r == COMMIT) & hit;
    assign pop_s     = evt_valid & evt_ready;
    assign full_s    = (count_r == FULL_CNT);
    assign wr_en_s   = push_s & (~full_s | pop_s);
    assign evt_valid = (count_r != '0);
    assign evt_index = mem_r[rd_ptr_r];

    // Hit event FIFO, overflow flag and saturating score
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            evt_overflow <= 1'b0;
            score        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= hit_index[IDX_W-1:0];
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && full_s && !pop_s) begin
                evt_overflow <= 1'b1;
            end
            if (push_s && (score != {SCORE_W{1'b1}})) begin
                score <= score + SCORE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hit_tracker.sv
// Directed self-checking bench for hit_tracker (default parameters).
module tb_hit_tracker;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk, click, WritePixel, evt_ready;
    logic [9:0]  WriteX, WriteY;
    logic [63:0] tbest;
    logic [1:0]  best_in;
    logic [79:0] probe_xy;
    logic [3:0]  hit_mask;
    logic [7:0]  hit_index;
    logic        hit, evt_valid, evt_overflow;
    logic [1:0]  evt_index;
    logic [15:0] score;

    localparam logic [63:0] T_MISS = 64'hEFFFFFFFFFFFFFFF;
`ifdef HIT_TRACKER_DEBOUNCE_EN
    localparam int CLICK_CYC = 20;
    localparam int CLICK_TAIL = 3;
`else
    localparam int CLICK_CYC = 1;
    localparam int CLICK_TAIL = 0;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int exp_score = 0;

    hit_tracker dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .click(click),
        .WritePixel(WritePixel), .WriteX(WriteX), .WriteY(WriteY),
        .tbest(tbest), .best_in(best_in), .probe_xy(probe_xy),
        .hit_mask(hit_mask), .hit_index(hit_index), .hit(hit),
        .evt_valid(evt_valid), .evt_index(evt_index), .evt_ready(evt_ready),
        .evt_overflow(evt_overflow), .score(score)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_px(input logic [9:0] x, input logic [9:0] y,
                            input logic [63:0] t, input logic [1:0] idx);
        WritePixel = 1'b1; WriteX = x; WriteY = y; tbest = t; best_in = idx;
        tick();
        WritePixel = 1'b0;
    endtask

    task automatic do_click();
        click = 1'b1;
        repeat (CLICK_CYC) tick();
        click = 1'b0;
        repeat (CLICK_TAIL) tick();
    endtask

    // after return, committed outputs of the closed frame are visible; FSM is in COMMIT
    task automatic frame_edge();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) tick();
        n_checks++; if (hit_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_hit_mask got %b exp 0000", hit_mask); end
        n_checks++; if (hit_index !== 8'h00) begin n_fail++; $display("FAIL reset_hit_index got %h exp 00", hit_index); end
        n_checks++; if ({hit, evt_valid, evt_overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {hit, evt_valid, evt_overflow}); end
        n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score got %0d exp 0", score); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_hit();
        write_px(10'd320, 10'd240, 64'h100, 2'd2);
        do_click();
        frame_edge();
        n_checks++; if (hit_mask !== 4'b0001) begin n_fail++; $display("FAIL basic_mask got %b exp 0001", hit_mask); end
        n_checks++; if (hit_index[1:0] !== 2'd2) begin n_fail++; $display("FAIL basic_index got %0d exp 2", hit_index[1:0]); end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit got %b exp 1", hit); end
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_evt_early got %b exp 0", evt_valid); end
        tick();
        exp_score++;
        n_checks++; if (evt_valid !== 1'b1 || evt_index !== 2'd2) begin n_fail++; $display("FAIL basic_evt got v=%b i=%0d exp v=1 i=2", evt_valid, evt_index); end
        n_checks++; if (score !== 16'(exp_score)) begin n_fail++; $display("FAIL basic_score got %0d exp %0d", score, exp_score); end
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got %b exp 0", evt_valid); end
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        n_checks++; if (evt_valid !== 1'b0 || evt_overflow !== 1'b0) begin n_fail++; $display("FAIL empty_pop got v=%b o=%b exp 0 0", evt_valid, evt_overflow); end
    endtask

    task automatic test_closest();
        write_px(10'd320, 10'd240, 64'h200, 2'd1);
        write_px(10'd320, 10'd240, 64'h080, 2'd3);
        write_px(10'd320, 10'd240, 64'h080, 2'd2);
        frame_edge();
        n_checks++; if (hit_index[1:0] !== 2'd3 || hit_mask[0] !== 1'b1) begin n_fail++; $display("FAIL closest_index got %0d m=%b exp 3 m=1", hit_index[1:0], hit_mask[0]); end
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL closest_hit got %b exp 0", hit); end
        tick();
        n_checks++; if (evt_valid !== 1'b0 || score !== 16'(exp_score)) begin n_fail++; $display("FAIL closest_noevt got v=%b s=%0d exp v=0 s=%0d", evt_valid, score, exp_score); end
    endtask

    task automatic test_miss_and_edge_write();
        write_px(10'd320, 10'd240, T_MISS, 2'd1);
        frame_clk = 1'b1;
        write_px(10'd320, 10'd240, 64'h10, 2'd1);
        frame_clk = 1'b0;
        n_checks++; if (hit_mask[0] !== 1'b0) begin n_fail++; $display("FAIL miss_commit got %b exp 0", hit_mask[0]); end
        tick();
        frame_edge();
        n_checks++; if (hit_mask[0] !== 1'b0) begin n_fail++; $display("FAIL edge_write_dropped got %b exp 0", hit_mask[0]); end
        tick();
    endtask

    task automatic test_edge_click();
        write_px(10'd320, 10'd240, 64'h100, 2'd0);
        frame_clk = 1'b1; click = 1'b1;
        tick();
        frame_clk = 1'b0; click = 1'b0;
        n_checks++; if (hit !== 1'b0 || hit_mask[0] !== 1'b1) begin n_fail++; $display("FAIL edge_click_old got h=%b m=%b exp h=0 m=1", hit, hit_mask[0]); end
        tick();
        write_px(10'd320, 10'd240, 64'h100, 2'd1);
        frame_edge();
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL edge_click_new got %b exp 1", hit); end
        tick();
        exp_score++;
        n_checks++; if (evt_index !== 2'd1 || score !== 16'(exp_score)) begin n_fail++; $display("FAIL edge_click_evt got i=%0d s=%0d exp i=1 s=%0d", evt_index, score, exp_score); end
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    endtask

    task automatic test_two_probes();
        write_px(10'd10, 10'd20, 64'h300, 2'd1);
        write_px(10'd320, 10'd240, 64'h050, 2'd3);
        write_px(10'd10, 10'd20, 64'h020, 2'd2);
        frame_edge();
        n_checks++; if (hit_mask !== 4'b0011) begin n_fail++; $display("FAIL two_mask got %b exp 0011", hit_mask); end
        n_checks++; if (hit_index !== 8'b0000_1011) begin n_fail++; $display("FAIL two_index got %b exp 00001011", hit_index); end
        tick();
    endtask

    task automatic hit_frame(input logic [1:0] idx, input logic rdy);
        write_px(10'd320, 10'd240, 64'h40, idx);
        do_click();
        frame_edge();
        evt_ready = rdy;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [1:0] exp_q [4];
        exp_q[0] = 2'd1; exp_q[1] = 2'd2; exp_q[2] = 2'd3; exp_q[3] = 2'd1;
        hit_frame(2'd0, 1'b0);
        hit_frame(2'd1, 1'b0);
        hit_frame(2'd2, 1'b0);
        hit_frame(2'd3, 1'b0);
        n_checks++; if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", evt_overflow); end
        hit_frame(2'd2, 1'b0);
        exp_score += 5;
        n_checks++; if (evt_overflow !== 1'b1 || score !== 16'(exp_score)) begin n_fail++; $display("FAIL ovf_set got o=%b s=%0d exp o=1 s=%0d", evt_overflow, score, exp_score); end
        hit_frame(2'd1, 1'b1);
        exp_score++;
        n_checks++; if (score !== 16'(exp_score)) begin n_fail++; $display("FAIL ovf_score got %0d exp %0d", score, exp_score); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (evt_valid !== 1'b1 || evt_index !== exp_q[i]) begin n_fail++; $display("FAIL drain_%0d got v=%b i=%0d exp v=1 i=%0d", i, evt_valid, evt_index, exp_q[i]); end
            evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        end
        n_checks++; if (evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin n_fail++; $display("FAIL drain_empty got v=%b o=%b exp v=0 o=1", evt_valid, evt_overflow); end
    endtask

    task automatic test_reset_mid_frame();
        write_px(10'd320, 10'd240, 64'h100, 2'd2);
        do_click();
        Reset = 1'b1;
        #1;
        n_checks++; if (score !== 16'd0 || evt_overflow !== 1'b0) begin n_fail++; $display("FAIL async_reset got s=%0d o=%b exp 0 0", score, evt_overflow); end
        tick();
        Reset = 1'b0;
        exp_score = 0;
        tick();
        frame_edge();
        n_checks++; if (hit_mask !== 4'b0000 || hit !== 1'b0) begin n_fail++; $display("FAIL reset_mid_commit got m=%b h=%b exp 0000 0", hit_mask, hit); end
        tick();
        n_checks++; if (evt_valid !== 1'b0 || score !== 16'd0) begin n_fail++; $display("FAIL reset_mid_evt got v=%b s=%0d exp 0 0", evt_valid, score); end
    endtask

`ifdef HIT_TRACKER_DEBOUNCE_EN
    task automatic test_debounce();
        write_px(10'd320, 10'd240, 64'h100, 2'd3);
        click = 1'b1; repeat (10) tick(); click = 1'b0; repeat (3) tick();
        frame_edge();
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL debounce_short got %b exp 0", hit); end
        tick();
        write_px(10'd320, 10'd240, 64'h100, 2'd3);
        click = 1'b1; repeat (20) tick(); click = 1'b0; repeat (3) tick();
        frame_edge();
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL debounce_long got %b exp 1", hit); end
        tick();
    endtask
`endif

    initial begin
        frame_clk = 1'b0; click = 1'b0; WritePixel = 1'b0; evt_ready = 1'b0;
        WriteX = 10'd0; WriteY = 10'd0; tbest = 64'd0; best_in = 2'd0;
        probe_xy = {10'd639, 10'd479, 10'd100, 10'd200, 10'd10, 10'd20, 10'd320, 10'd240};
        test_reset();
        test_basic_hit();
        test_closest();
        test_miss_and_edge_write();
`ifndef HIT_TRACKER_DEBOUNCE_EN
        test_edge_click();
`endif
        test_two_probes();
        test_overflow();
        test_reset_mid_frame();
`ifdef HIT_TRACKER_DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
